// File: rtl/led_panel_pkg.sv
// -----------------------------------------------------------------------------
// led_panel_pkg
// Shared constants and types for the HUB75 panel receiver (led_panel_rx).
//   COLS   : pixels shifted per latch (columns per row-pair)
//   ROW_W  : width of the ROW address bus (2**ROW_W row-pairs)
//   CNT_W  : width of the saturating NOE-low on-time counter
//   PIX_W  : bits per column as written out, {RGB1,RGB0}
//   state_e: dump FSM encoding
// -----------------------------------------------------------------------------
package led_panel_pkg;

    localparam int COLS  = 64;
    localparam int ROW_W = 5;
    localparam int CNT_W = 16;
    localparam int PIX_W = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // waiting for a latch strobe
        ST_DUMP = 2'd1,   // streaming the captured row-pair, one column per clk
        ST_DONE = 2'd2    // one-cycle row_done pulse
    } state_e;

endpackage

// File: rtl/led_panel_rx_sync_edge.sv
// -----------------------------------------------------------------------------
// sync_edge
// Two-flop synchroniser for an asynchronous single-bit input followed by a
// registered rising-edge detector. The pulse appears three clocks after the
// input edge is first sampled (2 sync + 1 edge register).
// Ports:
//   clk    in   system clock
//   rst    in   synchronous, active-high reset (clears all flops)
//   d_i    in   asynchronous input
//   rise_o out  one-clk pulse per rising edge of the synchronised input
// -----------------------------------------------------------------------------
module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic rise_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;
    logic rise_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour, forming a true shift chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
            rise_q <= sync_q & ~prev_q;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/led_panel_rx.sv
// -----------------------------------------------------------------------------
// led_panel_rx
// Receiving end of a HUB75 panel link: behaves as the LED panel. Samples the
// panel pins in the system clock domain, deserialises one row-pair per latch
// strobe and dumps it column by column through a pixel write port addressed
// {row, col}. Also measures how long NOE was low between latches.
// Ports:
//   clk        in   system clock, all logic on posedge
//   rst        in   synchronous, active-high reset
//   SCLK       in   panel shift clock (async, period >= 4 clk)
//   LATCH      in   latch strobe, rising edge transfers shift register to row
//   NOE        in   output enable, active low
//   ROW        in   row-pair address
//   RGB0/RGB1  in   upper/lower half pixel {R,G,B}
//   wr_en      out  pixel write strobe, one clk per column
//   wr_addr    out  {row_latched, col}
//   wr_data    out  {RGB1,RGB0} of that column
//   row_done   out  1-clk pulse after the last column of a row-pair
//   on_cycles  out  NOE-low clk count since the previous latch, valid at row_done
//   err_count  out  sticky: latch seen with a shift count other than COLS
//   err_ovl    out  sticky: latch seen while a dump was still in progress
// -----------------------------------------------------------------------------
module led_panel_rx
    import led_panel_pkg::*;
#(
    parameter int COLS  = led_panel_pkg::COLS,
    parameter int ROW_W = led_panel_pkg::ROW_W,
    parameter int CNT_W = led_panel_pkg::CNT_W
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           SCLK,
    input  logic                           LATCH,
    input  logic                           NOE,
    input  logic [ROW_W-1:0]               ROW,
    input  logic [2:0]                     RGB0,
    input  logic [2:0]                     RGB1,
    output logic                           wr_en,
    output logic [ROW_W+$clog2(COLS)-1:0]  wr_addr,
    output logic [PIX_W-1:0]               wr_data,
    output logic                           row_done,
    output logic [CNT_W-1:0]               on_cycles,
    output logic                           err_count,
    output logic                           err_ovl
);

    localparam int COL_W = $clog2(COLS);
    localparam int BIT_W = $clog2(COLS + 2);      // must hold COLS+1
    localparam int SH_W  = COLS * PIX_W;

    localparam logic [BIT_W-1:0] BIT_FULL = BIT_W'(COLS);
    localparam logic [BIT_W-1:0] BIT_SAT  = BIT_W'(COLS + 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
    localparam logic [CNT_W-1:0] ON_MAX   = '1;

    // ---------------------------------------------------------------- inputs
    logic sclk_rise;
    logic latch_rise;

    sync_edge u_sclk_sync (
        .clk    (clk),
        .rst    (rst),
        .d_i    (SCLK),
        .rise_o (sclk_rise)
    );

    sync_edge u_latch_sync (
        .clk    (clk),
        .rst    (rst),
        .d_i    (LATCH),
        .rise_o (latch_rise)
    );

    // NOE is carried inverted (output-enabled = 1) so the cleared reset value
    // of the synchroniser means "dark" and does not count as on-time.
    logic             oe_meta_q,  oe_sync_q;
    logic [ROW_W-1:0] row_meta_q, row_sync_q;
    logic [PIX_W-1:0] rgb_meta_q, rgb_sync_q;

    // ------------------------------------------------------------------ state
    logic [SH_W-1:0]  shreg_q,       shreg_d,  shreg_sh;
    logic [BIT_W-1:0] bit_cnt_q,     bit_cnt_d, bit_cnt_sh;
    logic [CNT_W-1:0] on_acc_q,      on_acc_d;
    logic [CNT_W-1:0] on_hold_q,     on_hold_d;
    logic [CNT_W-1:0] on_cycles_q,   on_cycles_d;
    logic [SH_W-1:0]  row_buf_q,     row_buf_d;
    logic [ROW_W-1:0] row_latched_q, row_latched_d;
    logic [COL_W-1:0] col_q,         col_d;
    logic             err_count_q,   err_count_d;
    logic             err_ovl_q,     err_ovl_d;
    state_e           state_q,       state_d;

    // ----------------------------------------------- shift / latch datapath
    // NOTE: every combinational output gets a default before any branch so no
    // path leaves a signal unassigned, which would infer a latch.
    always_comb begin
        shreg_sh    = shreg_q;
        bit_cnt_sh  = bit_cnt_q;
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        on_acc_d    = on_acc_q;
        err_count_d = err_count_q;
        err_ovl_d   = err_ovl_q;

        // Column 0 is shifted first and ends up in the top slice.
        if (sclk_rise) begin
            shreg_sh = {shreg_q[SH_W-PIX_W-1:0], rgb_sync_q};
            if (bit_cnt_q != BIT_SAT) begin
                bit_cnt_sh = bit_cnt_q + 1'b1;
            end
        end
        shreg_d   = shreg_sh;
        bit_cnt_d = bit_cnt_sh;

        if (oe_sync_q && (on_acc_q != ON_MAX)) begin
            on_acc_d = on_acc_q + 1'b1;
        end

        // A shift in the same clk as the latch is counted before the check.
        if (latch_rise) begin
            if (bit_cnt_sh != BIT_FULL) begin
                err_count_d = 1'b1;
            end
            if (state_q != ST_IDLE) begin
                err_ovl_d = 1'b1;
            end
            shreg_d   = '0;
            bit_cnt_d = '0;
            on_acc_d  = '0;
        end
    end

    // ------------------------------------------------------------- dump FSM
    always_comb begin
        state_d       = state_q;
        col_d         = col_q;
        row_buf_d     = row_buf_q;
        row_latched_d = row_latched_q;
        on_hold_d     = on_hold_q;
        on_cycles_d   = on_cycles_q;
        wr_en         = 1'b0;
        row_done      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Only an idle receiver accepts a row; a latch while busy is
                // flagged above and its data dropped.
                if (latch_rise) begin
                    state_d       = ST_DUMP;
                    col_d         = '0;
                    row_buf_d     = shreg_sh;
                    row_latched_d = row_sync_q;
                    on_hold_d     = on_acc_q;
                end
            end
            ST_DUMP: begin
                wr_en     = 1'b1;
                row_buf_d = row_buf_q << PIX_W;   // next column moves to the top
                col_d     = col_q + 1'b1;
                if (col_q == COL_LAST) begin
                    state_d     = ST_DONE;
                    col_d       = '0;
                    on_cycles_d = on_hold_q;      // present during row_done
                end
            end
            ST_DONE: begin
                row_done = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------- registers
    always_ff @(posedge clk) begin
        if (rst) begin
            oe_meta_q     <= 1'b0;
            oe_sync_q     <= 1'b0;
            row_meta_q    <= '0;
            row_sync_q    <= '0;
            rgb_meta_q    <= '0;
            rgb_sync_q    <= '0;
            // NOTE: the wide shift and row buffers are cleared too, so a row
            // latched with missing columns after reset reads those as 0.
            shreg_q       <= '0;
            row_buf_q     <= '0;
            bit_cnt_q     <= '0;
            on_acc_q      <= '0;
            on_hold_q     <= '0;
            on_cycles_q   <= '0;
            row_latched_q <= '0;
            col_q         <= '0;
            err_count_q   <= 1'b0;
            err_ovl_q     <= 1'b0;
            state_q       <= ST_IDLE;
        end else begin
            oe_meta_q     <= ~NOE;
            oe_sync_q     <= oe_meta_q;
            row_meta_q    <= ROW;
            row_sync_q    <= row_meta_q;
            rgb_meta_q    <= {RGB1, RGB0};
            rgb_sync_q    <= rgb_meta_q;
            shreg_q       <= shreg_d;
            row_buf_q     <= row_buf_d;
            bit_cnt_q     <= bit_cnt_d;
            on_acc_q      <= on_acc_d;
            on_hold_q     <= on_hold_d;
            on_cycles_q   <= on_cycles_d;
            row_latched_q <= row_latched_d;
            col_q         <= col_d;
            err_count_q   <= err_count_d;
            err_ovl_q     <= err_ovl_d;
            state_q       <= state_d;
        end
    end

    // ---------------------------------------------------------------- outputs
    assign wr_addr   = wr_en ? {row_latched_q, col_q} : '0;
    assign wr_data   = wr_en ? row_buf_q[SH_W-1 -: PIX_W] : '0;
    assign on_cycles = on_cycles_q;
    assign err_count = err_count_q;
    assign err_ovl   = err_ovl_q;

endmodule

// File: tb/tb_led_panel_rx.sv
// -----------------------------------------------------------------------------
// tb_led_panel_rx
// Drives the receiver like a HUB75 driver would and checks its write port
// against expected writes queued at stimulus time. A monitor pops and compares
// whenever wr_en or row_done is presented.
// -----------------------------------------------------------------------------
module tb_led_panel_rx;

    localparam int COLS  = 64;
    localparam int ROW_W = 5;
    localparam int CNT_W = 16;
    localparam int AW    = ROW_W + 6;

    logic             clk   = 1'b0;
    logic             rst   = 1'b1;
    logic             SCLK  = 1'b0;
    logic             LATCH = 1'b0;
    logic             NOE   = 1'b1;
    logic [ROW_W-1:0] ROW   = '0;
    logic [2:0]       RGB0  = '0;
    logic [2:0]       RGB1  = '0;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [5:0]       wr_data;
    logic             row_done;
    logic [CNT_W-1:0] on_cycles;
    logic             err_count;
    logic             err_ovl;

    led_panel_rx #(.COLS(COLS), .ROW_W(ROW_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .SCLK      (SCLK),
        .LATCH     (LATCH),
        .NOE       (NOE),
        .ROW       (ROW),
        .RGB0      (RGB0),
        .RGB1      (RGB1),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .row_done  (row_done),
        .on_cycles (on_cycles),
        .err_count (err_count),
        .err_ovl   (err_ovl)
    );

    always #5 clk = ~clk;

    int            n_cmp   = 0;
    int            n_bad   = 0;
    int            rd_seen = 0;
    logic [AW+5:0] wq[$];          // expected {addr, data}
    int            rdq[$];         // expected on_cycles per row_done
    logic [5:0]    pix [COLS];
    logic [5:0]    mem [2**AW];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    function automatic logic [5:0] img(input int r, input int c);
        return 6'((r * 5) + (c * 3) + (r ^ c));
    endfunction

    // ------------------------------------------------------------- monitor
    initial begin
        logic [AW+5:0] e;
        int            eo;
        forever begin
            @(negedge clk);
            if (wr_en) begin
                mem[wr_addr] = wr_data;
                if (wq.size() == 0) begin
                    fail_now("unexpected_write");
                end else begin
                    e = wq.pop_front();
                    check("write", 32'({wr_addr, wr_data}), 32'(e));
                end
            end
            if (row_done) begin
                rd_seen++;
                if (rdq.size() == 0) begin
                    fail_now("unexpected_row_done");
                end else begin
                    eo = rdq.pop_front();
                    check("on_cycles", 32'(on_cycles), 32'(eo));
                end
            end
        end
    end

    // --------------------------------------------------------------- tasks
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; SCLK = 1'b0; LATCH = 1'b0; NOE = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Shift nshift columns of pix[] then latch. The expected row holds the
    // shifted columns right-aligned (missing leading columns read as 0).
    task automatic send_row(input int row, input int nshift, input int n_push,
                            input int exp_on, input bit merge, output int lat);
        int         off;
        logic [5:0] d;
        off = COLS - nshift;
        for (int c = 0; c < n_push; c++) begin
            if (c >= off) d = pix[c-off];
            else          d = 6'd0;
            wq.push_back({AW'(row * COLS + c), d});
        end
        if (n_push == COLS) rdq.push_back(exp_on);
        for (int i = 0; i < nshift; i++) begin
            @(negedge clk);
            SCLK = 1'b0; RGB1 = pix[i][5:3]; RGB0 = pix[i][2:0];
            repeat (2) @(negedge clk);
            if (!(merge && i == nshift - 1)) begin
                SCLK = 1'b1;
                repeat (2) @(negedge clk);
            end
        end
        ROW = row[ROW_W-1:0];
        LATCH = 1'b1;
        if (merge) SCLK = 1'b1;
        lat = -1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (wr_en && lat < 0) lat = k;
            if (k == 2) LATCH = 1'b0;
        end
    endtask

    task automatic latch_only(input int row);
        @(negedge clk);
        ROW = row[ROW_W-1:0]; LATCH = 1'b1;
        repeat (2) @(negedge clk);
        LATCH = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((wq.size() != 0 || rdq.size() != 0) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 3000) begin
            fail_now("drain_timeout");
            wq.delete();
            rdq.delete();
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_wr_en"},     32'(wr_en),     32'd0);
        check({tag, "_wr_addr"},   32'(wr_addr),   32'd0);
        check({tag, "_wr_data"},   32'(wr_data),   32'd0);
        check({tag, "_row_done"},  32'(row_done),  32'd0);
        check({tag, "_on_cycles"}, 32'(on_cycles), 32'd0);
        check({tag, "_err_count"}, 32'(err_count), 32'd0);
        check({tag, "_err_ovl"},   32'(err_ovl),   32'd0);
    endtask

    // ------------------------------------------------------------ stimulus
    initial begin
        int lat;
        int t;

        // Reset state
        do_reset();
        check_idle_outputs("reset");

        // Basic row: RGB0=c, RGB1=~c on row 5, plus pin-to-write latency
        for (int c = 0; c < COLS; c++) pix[c] = {~3'(c), 3'(c)};
        send_row(5, COLS, COLS, 0, 1'b0, lat);
        check("latch_latency", 32'(lat), 32'd4);
        drain();
        check("basic_err_count", 32'(err_count), 32'd0);
        check("basic_err_ovl",   32'(err_ovl),   32'd0);

        // NOE low for 1000 clk between two latches
        do_reset();
        for (int c = 0; c < COLS; c++) pix[c] = 6'(c * 7 + 1);
        send_row(1, COLS, COLS, 0, 1'b0, lat);
        @(negedge clk); NOE = 1'b0;
        repeat (1000) @(negedge clk);
        NOE = 1'b1;
        for (int c = 0; c < COLS; c++) pix[c] = 6'(63 - c);
        send_row(2, COLS, COLS, 1000, 1'b0, lat);
        drain();

        // Short row: 63 shifts then latch
        do_reset();
        for (int c = 0; c < COLS; c++) pix[c] = 6'(c + 1);
        send_row(3, COLS - 1, COLS, 0, 1'b0, lat);
        drain();
        check("short_err_count", 32'(err_count), 32'd1);
        check("short_err_ovl",   32'(err_ovl),   32'd0);

        // Last SCLK rise coincides with LATCH rise: shift counts first
        do_reset();
        for (int c = 0; c < COLS; c++) pix[c] = 6'(c ^ 6'h2a);
        send_row(4, COLS, COLS, 0, 1'b1, lat);
        drain();
        check("merge_err_count", 32'(err_count), 32'd0);
        check("merge_err_ovl",   32'(err_ovl),   32'd0);

        // Second latch 10 clk after the first, during the dump
        do_reset();
        for (int c = 0; c < COLS; c++) pix[c] = 6'(c * 3);
        send_row(6, COLS, COLS, 0, 1'b0, lat);
        repeat (2) @(negedge clk);
        latch_only(9);
        drain();
        check("ovl_err_ovl",   32'(err_ovl),   32'd1);
        check("ovl_err_count", 32'(err_count), 32'd1);

        // Reset at column 20 of a dump, then a clean row
        do_reset();
        for (int c = 0; c < COLS; c++) pix[c] = 6'(c + 17);
        send_row(10, COLS, 21, 0, 1'b0, lat);
        t = 0;
        while (!(wr_en && wr_addr[5:0] == 6'd20) && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) fail_now("col20_timeout");
        rst = 1'b1; SCLK = 1'b0;
        @(negedge clk);
        check_idle_outputs("midrst");
        check("midrst_pending", 32'(wq.size()), 32'd0);
        wq.delete();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        for (int c = 0; c < COLS; c++) pix[c] = 6'(c * 5 + 2);
        send_row(7, COLS, COLS, 0, 1'b0, lat);
        drain();
        check("after_rst_err_count", 32'(err_count), 32'd0);

        // Full 32-row frame with 20 clk of display time per row
        do_reset();
        for (int i = 0; i < 2**AW; i++) mem[i] = 6'd0;
        rd_seen = 0;
        for (int r = 0; r < 32; r++) begin
            for (int c = 0; c < COLS; c++) pix[c] = img(r, c);
            send_row(r, COLS, COLS, (r == 0) ? 0 : 20, 1'b0, lat);
            @(negedge clk); NOE = 1'b0;
            repeat (20) @(negedge clk);
            NOE = 1'b1;
        end
        drain();
        check("frame_row_done", 32'(rd_seen), 32'd32);
        for (int r = 0; r < 32; r++) begin
            for (int c = 0; c < COLS; c++) begin
                check("frame_mem", 32'(mem[r * COLS + c]), 32'(img(r, c)));
            end
        end
        check("frame_err_count", 32'(err_count), 32'd0);
        check("frame_err_ovl",   32'(err_ovl),   32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
